// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU encodings and the
// control bundle carried from the decoder into the stage output register.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    illegal;
    logic    reads_rt;
  } ctrl_t;

  // Unknown encodings: no side effects, ALU defaults to ADD, reads nothing.
  localparam ctrl_t CTRL_ILLEGAL = '{
    alu_op:     ALU_ADD,
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    illegal:    1'b1,
    reads_rt:   1'b0
  };

  // Build a control bundle for a legal instruction.
  function automatic ctrl_t mk_ctrl(input alu_op_e op, input logic src,
                                    input logic rw, input logic mw,
                                    input logic m2r, input logic br,
                                    input logic rrt);
    ctrl_t c;
    c.alu_op     = op;
    c.alu_src    = src;
    c.reg_write  = rw;
    c.mem_write  = mw;
    c.mem_to_reg = m2r;
    c.branch     = br;
    c.illegal    = 1'b0;
    c.reads_rt   = rrt;
    return c;
  endfunction

  // R-type writes rd, everything else writes rt.
  function automatic logic [4:0] dest_sel(input logic [31:0] word);
    return (word[31:26] == OP_RTYPE) ? word[15:11] : word[20:16];
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: register fields, immediate and control.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      dest
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zext;
  logic       unused_shamt;

  assign opcode       = inst[31:26];
  assign funct        = inst[5:0];
  assign rs           = inst[25:21];
  assign rt           = inst[20:16];
  assign dest         = dest_sel(inst);
  assign unused_shamt = ^inst[10:6];

  // Translate opcode/funct into the control bundle; writes to $0 are dropped.
  always_comb begin
    ctrl = CTRL_ILLEGAL;
    zext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          FN_SUB:  ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          FN_AND:  ctrl = mk_ctrl(ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          FN_OR:   ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          FN_SLT:  ctrl = mk_ctrl(ALU_SLT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
          default: ctrl = CTRL_ILLEGAL;
        endcase
      end
      OP_ADDI: ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      OP_ANDI: begin
        ctrl = mk_ctrl(ALU_AND, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        zext = 1'b1;
      end
      OP_ORI: begin
        ctrl = mk_ctrl(ALU_OR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        zext = 1'b1;
      end
      OP_LW:   ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      OP_SW:   ctrl = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      OP_BEQ:  ctrl = mk_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      default: ctrl = CTRL_ILLEGAL;
    endcase
    ctrl.reg_write = ctrl.reg_write & (dest != 5'd0);
  end

  assign imm = zext ? {{(XLEN-16){1'b0}}, inst[15:0]}
                    : {{(XLEN-16){inst[15]}}, inst[15:0]};

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: handshake, output register, load-use hazard
// bubble, flush and a saturating hazard-stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       dest,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs;
  logic [4:0]      dec_rt;
  logic [4:0]      dec_dest;
  logic            hazard;
  logic            accept;
  logic            stall_inc;

  decode_ctrl #(.XLEN(XLEN)) u_ctrl (
    .inst (inst),
    .ctrl (dec_ctrl),
    .imm  (dec_imm),
    .rs   (dec_rs),
    .rt   (dec_rt),
    .dest (dec_dest)
  );

  // Load-use check: held LW writing a non-zero reg that the offered op reads.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN && out_valid && mem_to_reg && (dest != 5'd0)) begin
      hazard = (!dec_ctrl.illegal && (dec_rs == dest)) ||
               (dec_ctrl.reads_rt && (dec_rt == dest));
    end else begin
      hazard = 1'b0;
    end
  end

  // Reset gates ready so nothing is taken while the stage is held in reset.
  assign in_ready  = rst_n & ~flush & (~out_valid | out_ready) & ~hazard;
  assign accept    = in_valid & in_ready;
  assign stall_inc = in_valid & hazard & ~flush;

  // Output register: flush empties it, acceptance reloads it, a transfer
  // without a replacement empties it, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      rs         <= 5'd0;
      rt         <= 5'd0;
      dest       <= 5'd0;
      imm        <= '0;
      alu_op     <= 3'b000;
      alu_src    <= 1'b0;
      reg_write  <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_pc     <= in_pc;
      rs         <= dec_rs;
      rt         <= dec_rt;
      dest       <= dec_dest;
      imm        <= dec_imm;
      alu_op     <= dec_ctrl.alu_op;
      alu_src    <= dec_ctrl.alu_src;
      reg_write  <= dec_ctrl.reg_write;
      mem_write  <= dec_ctrl.mem_write;
      mem_to_reg <= dec_ctrl.mem_to_reg;
      branch     <= dec_ctrl.branch;
      illegal    <= dec_ctrl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Count cycles an offered instruction waits on a load-use hazard; saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions with hand-decoded
// expectations queued at acceptance and checked by an output monitor.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, in_pc, out_pc, imm;
  logic [4:0]  rs, rt, dest;
  logic [2:0]  alu_op;
  logic        alu_src, reg_write, mem_write, mem_to_reg, branch, illegal;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_imm;
  logic [4:0]  s_rs, s_rt, s_dest;
  logic [2:0]  s_alu_op;
  logic        s_alu_src, s_reg_write, s_mem_write, s_mem_to_reg, s_branch, s_illegal;
  logic [1:0]  s_stall_cnt;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(16), .HAZARD_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs(rs), .rt(rt), .dest(dest),
    .imm(imm), .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
    .illegal(illegal), .stall_cnt(stall_cnt));

  decode_stage #(.XLEN(32), .CNT_W(2), .HAZARD_EN(1'b1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .inst(inst), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .rs(s_rs), .rt(s_rt), .dest(s_dest),
    .imm(s_imm), .alu_op(s_alu_op), .alu_src(s_alu_src), .reg_write(s_reg_write),
    .mem_write(s_mem_write), .mem_to_reg(s_mem_to_reg), .branch(s_branch),
    .illegal(s_illegal), .stall_cnt(s_stall_cnt));

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs, rt, dest;
    logic [31:0] imm;
    logic [2:0]  alu;
    logic [5:0]  flags;  // {alu_src, reg_write, mem_write, mem_to_reg, branch, illegal}
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          pop_n = 0;
  int          pop_cyc[256];
  int          exp_stall = 0;
  logic [31:0] pc_ctr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [31:0] im,
                              input logic [2:0] op, input logic [5:0] fl);
    exp_t e;
    e.pc = 32'h0; e.rs = s; e.rt = t; e.dest = d; e.imm = im; e.alu = op; e.flags = fl;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.pc = out_pc; a.rs = rs; a.rt = rt; a.dest = dest; a.imm = imm; a.alu = alu_op;
    a.flags = {alu_src, reg_write, mem_write, mem_to_reg, branch, illegal};
    return a;
  endfunction

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t act, ex;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      act = sample();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out act=%h exp=none", act);
      end else begin
        ex = sb.pop_front();
        if (act !== ex) begin
          bad++;
          $display("FAIL out_fields pc=%h act=%h exp=%h", ex.pc, act, ex);
        end
      end
      if (pop_n < 256) pop_cyc[pop_n] = cyc;
      pop_n++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input exp_t e, output int acc);
    exp_t ex;
    bit   ok;
    ex = e; ex.pc = pc_ctr;
    in_valid = 1'b1; inst = w; in_pc = pc_ctr; ok = 1'b0; acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1; acc = cyc; sb.push_back(ex);
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout pc=%h act=stuck exp=accepted", pc_ctr);
    end
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  task automatic chk_stall();
    chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
    chk("stall_cnt_sat", 128'(s_stall_cnt), 128'((exp_stall > 3) ? 3 : exp_stall));
  endtask

  localparam logic [31:0] W_LW5    = 32'h8C250000;  // lw  $5,0($1)
  localparam logic [31:0] W_ADDDEP = 32'h00A53020;  // add $6,$5,$5
  localparam logic [31:0] W_ADDIND = 32'h00E73020;  // add $6,$7,$7
  localparam logic [31:0] W_ADD3   = 32'h00221820;  // add $3,$1,$2

  initial begin
    logic [31:0] words[13];
    exp_t        exps[13];
    exp_t        e_lw, e_dep, e_ind, e_add3, e_a, e_b;
    int          acc, base;

    e_lw   = mk(5'd1, 5'd5, 5'd5, 32'h0, 3'd0, 6'b110100);
    e_dep  = mk(5'd5, 5'd5, 5'd6, 32'h3020, 3'd0, 6'b010000);
    e_ind  = mk(5'd7, 5'd7, 5'd6, 32'h3020, 3'd0, 6'b010000);
    e_add3 = mk(5'd1, 5'd2, 5'd3, 32'h1820, 3'd0, 6'b010000);

    rst_n = 1'b0; in_valid = 1'b0; inst = 32'h0; in_pc = 32'h0; flush = 1'b0;
    out_ready = 1'b1; pc_ctr = 32'h1000;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_fields", 128'(sample()), 128'd0);
    chk_stall();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First instruction after reset: one-cycle latency.
    send(W_ADD3, e_add3, acc);
    drain();
    chk("latency", 128'(pop_cyc[pop_n-1]), 128'(acc + 1));

    // Back-to-back decode table sweep at full throughput.
    words[0]  = 32'h00221822; exps[0]  = mk(5'd1, 5'd2, 5'd3, 32'h1822, 3'd1, 6'b010000);
    words[1]  = 32'h00221824; exps[1]  = mk(5'd1, 5'd2, 5'd3, 32'h1824, 3'd2, 6'b010000);
    words[2]  = 32'h00221825; exps[2]  = mk(5'd1, 5'd2, 5'd3, 32'h1825, 3'd3, 6'b010000);
    words[3]  = 32'h0022182A; exps[3]  = mk(5'd1, 5'd2, 5'd3, 32'h182A, 3'd4, 6'b010000);
    words[4]  = 32'h30248000; exps[4]  = mk(5'd1, 5'd4, 5'd4, 32'h00008000, 3'd2, 6'b110000);
    words[5]  = 32'h3404FFFF; exps[5]  = mk(5'd0, 5'd4, 5'd4, 32'h0000FFFF, 3'd3, 6'b110000);
    words[6]  = 32'h2004FFFF; exps[6]  = mk(5'd0, 5'd4, 5'd4, 32'hFFFFFFFF, 3'd0, 6'b110000);
    words[7]  = 32'hFC221820; exps[7]  = mk(5'd1, 5'd2, 5'd2, 32'h1820, 3'd0, 6'b000001);
    words[8]  = 32'h00221821; exps[8]  = mk(5'd1, 5'd2, 5'd3, 32'h1821, 3'd0, 6'b000001);
    words[9]  = 32'h00220020; exps[9]  = mk(5'd1, 5'd2, 5'd0, 32'h0020, 3'd0, 6'b000000);
    words[10] = 32'hAC220004; exps[10] = mk(5'd1, 5'd2, 5'd2, 32'h0004, 3'd0, 6'b101000);
    words[11] = 32'h10220008; exps[11] = mk(5'd1, 5'd2, 5'd2, 32'h0008, 3'd1, 6'b000010);
    words[12] = 32'h8C238004; exps[12] = mk(5'd1, 5'd3, 5'd3, 32'hFFFF8004, 3'd0, 6'b110100);
    base = pop_n;
    for (int i = 0; i < 13; i++) send(words[i], exps[i], acc);
    drain();
    chk("throughput", 128'(pop_cyc[base+12] - pop_cyc[base]), 128'd12);

    // Load-use pairs: gap between pops is 2 with a bubble, 1 without.
    base = pop_n; send(W_LW5, e_lw, acc); send(W_ADDDEP, e_dep, acc); drain();
    chk("bubble_rs", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd2);
    exp_stall = exp_stall + 1; chk_stall();
    base = pop_n; send(W_LW5, e_lw, acc); send(W_ADDIND, e_ind, acc); drain();
    chk("no_bubble_indep", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd1);
    chk_stall();
    base = pop_n; send(W_LW5, e_lw, acc);
    send(32'h34050001, mk(5'd0, 5'd5, 5'd5, 32'h1, 3'd3, 6'b110000), acc); drain();
    chk("no_bubble_ori_rt", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd1);
    base = pop_n; send(W_LW5, e_lw, acc);
    send(32'hAC250000, mk(5'd1, 5'd5, 5'd5, 32'h0, 3'd0, 6'b101000), acc); drain();
    chk("bubble_sw_rt", 128'(pop_cyc[base+1] - pop_cyc[base]), 128'd2);
    exp_stall = exp_stall + 1; chk_stall();

    // Back-pressure: held output stays stable, offered op waits.
    out_ready = 1'b0;
    e_a = mk(5'd1, 5'd2, 5'd3, 32'h1822, 3'd1, 6'b010000); e_a.pc = pc_ctr;
    send(32'h00221822, e_a, acc);
    e_b = mk(5'd1, 5'd2, 5'd3, 32'h1824, 3'd2, 6'b010000);
    in_valid = 1'b1; inst = 32'h00221824; in_pc = pc_ctr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_stable", 128'(sample()), 128'(e_a));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00221824, e_b, acc);
    drain();

    // Flush while holding SW and offering BEQ: neither appears.
    out_ready = 1'b0;
    send(32'hAC220004, mk(5'd1, 5'd2, 5'd2, 32'h0004, 3'd0, 6'b101000), acc);
    in_valid = 1'b1; inst = 32'h10220008; in_pc = pc_ctr; flush = 1'b1;
    pc_ctr = pc_ctr + 32'd4;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;

    // Flush over a load-use stall: no count, LW dropped.
    send(W_LW5, e_lw, acc);
    in_valid = 1'b1; inst = W_ADDDEP; in_pc = pc_ctr; flush = 1'b1;
    pc_ctr = pc_ctr + 32'd4;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    chk("flush_out_valid2", 128'(out_valid), 128'd0);
    chk_stall();
    out_ready = 1'b1;
    send(W_ADDIND, e_ind, acc);
    drain();

    // Long stall behind a held LW: narrow counter saturates.
    out_ready = 1'b0;
    send(W_LW5, e_lw, acc);
    in_valid = 1'b1; inst = W_ADDDEP; in_pc = pc_ctr;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_stall = exp_stall + 1;
      chk_stall();
    end
    out_ready = 1'b1;
    send(W_ADDDEP, e_dep, acc);
    drain();
    exp_stall = exp_stall + 1; chk_stall();

    // Asynchronous reset mid-stream, then decode resumes.
    out_ready = 1'b0;
    send(W_LW5, e_lw, acc);
    in_valid = 1'b1; inst = W_ADDDEP; in_pc = pc_ctr;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    chk("mid_rst_fields", 128'(sample()), 128'd0);
    sb.delete(); exp_stall = 0;
    chk_stall();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send(W_ADD3, e_add3, acc);
    drain();
    chk("latency_after_rst", 128'(pop_cyc[pop_n-1]), 128'(acc + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode pipeline stage between fetch and execute in the 32-bit MIPS-subset core. Each accepted 32-bit instruction is decoded into register addresses, a sign/zero-extended immediate and a control bundle held in an output register. The stage also detects load-use hazards and inserts a one-cycle bubble. It adds flush support, an illegal-instruction flag and a saturating stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width; IMM and PC are XLEN bits (XLEN >= 32).
- CNT_W, 16, width of the stall counter.
- HAZARD_EN, 1, 1 enables load-use stall detection; 0 disables it (IN_READY never held for hazards).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  fetch offers an instruction.
- IN_READY  out  1  stage accepts this cycle; transfer = IN_VALID & IN_READY.
- INST  in  32  instruction word.
- IN_PC  in  XLEN  PC of INST.
- FLUSH  in  1  discard the held and offered instruction (branch redirect).
- OUT_VALID  out  1  output register holds a decoded instruction.
- OUT_READY  in  1  execute accepts; transfer = OUT_VALID & OUT_READY.
- OUT_PC  out  XLEN  PC of the held instruction.
- RS, RT, DEST  out  5 each  source and destination registers; DEST = INST[15:11] for R-type, INST[20:16] otherwise.
- IMM  out  XLEN  INST[15:0], sign-extended (zero-extended for ANDI/ORI).
- ALU_OP  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- ALU_SRC  out  1  1 = IMM is operand B.
- REG_WRITE, MEM_WRITE, MEM_TO_REG, BRANCH, ILLEGAL  out  1 each  control bits.
- STALL_CNT  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Decode table. R-type instructions have opcode 000000:
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - REG_WRITE=1, ALU_SRC=0.
- I-type opcodes:
  - 001000 ADDI: ADD, REG_WRITE.
  - 001100 ANDI and 001101 ORI: zero-extended IMM, REG_WRITE.
  - 100011 LW: ADD, REG_WRITE, MEM_TO_REG.
  - 101011 SW: ADD, MEM_WRITE.
  - 000100 BEQ: SUB, BRANCH, ALU_SRC=0.
- Any other opcode or funct sets ILLEGAL=1 and forces REG_WRITE=MEM_WRITE=BRANCH=MEM_TO_REG=0 and ALU_OP=ADD. It is still passed downstream with OUT_VALID.
- REG_WRITE is forced to 0 when DEST==0.
- Reads: RS is read by every legal instruction. RT is read by R-type, SW and BEQ.
- Hazard: when HAZARD_EN=1 and the output register holds a valid LW with DEST!=0, an incoming instruction that reads DEST is not accepted while that LW is held. When the LW transfers, the output register becomes empty (bubble), and the dependent instruction is accepted the following cycle.
- IN_READY = !FLUSH & (!OUT_VALID | OUT_READY) & !hazard.
- STALL_CNT increments once per cycle in which IN_VALID=1 and hazard=1. It saturates at all-ones and never wraps.

## Timing
- Reset (RST_N=0, asynchronous): OUT_VALID=0; all decoded outputs, OUT_PC and STALL_CNT are 0. IN_READY is 0 while in reset. Any instruction held at reset is lost.
- Latency: 1 cycle from accepted INST to OUT_VALID with its decoded fields. Full throughput is 1 instruction/cycle with no hazards.
- Output fields are stable while OUT_VALID=1 and OUT_READY=0.
- OUT_VALID falls only after a transfer with no new acceptance, or on FLUSH.
- FLUSH has priority: the next cycle has OUT_VALID=0, the offered instruction is dropped (IN_READY=0), and no STALL_CNT increment.
- Simultaneous output transfer and input acceptance: the output register is replaced by the new instruction with no gap.

## Structure
- Package decode_pkg: opcode and funct constants, the ALU_OP encodings (enum), and a packed ctrl_t struct (ALU_OP, ALU_SRC, REG_WRITE, MEM_WRITE, MEM_TO_REG, BRANCH, ILLEGAL, reads_rt).
- Sub-module decode_ctrl: purely combinational, mapping INST to ctrl_t and IMM.
- decode_stage: output register, handshake, hazard logic and counter.

## Test plan
- Reset: assert RST_N=0 mid-stream -> OUT_VALID=0, STALL_CNT=0 immediately; after release, ADD $3,$1,$2 (0x00221820) -> one cycle later RS=1, RT=2, DEST=3, ALU_OP=000, REG_WRITE=1.
- ORI $4,$0,0xFFFF -> IMM=0x0000FFFF, ALU_SRC=1. ADDI $4,$0,-1 -> IMM=0xFFFFFFFF.
- LW $5,0($1) followed by ADD $6,$5,$5, OUT_READY=1 -> exactly one OUT_VALID=0 cycle between them, STALL_CNT=1. Same sequence with ADD $6,$7,$7 -> no bubble.
- OUT_READY held 0 for 3 cycles with IN_VALID=1 -> IN_READY=0, outputs stable, no instruction lost or duplicated.
- FLUSH while holding SW and offering BEQ -> next cycle OUT_VALID=0, neither instruction ever appears at the output.
- Opcode 111111 -> ILLEGAL=1, REG_WRITE=0, MEM_WRITE=0. ADD to $0 -> REG_WRITE=0. CNT_W=2 with 5 stall cycles -> STALL_CNT=3.
